// File: rtl/frame_assembler64_pkg.sv
// Shared constants and state encoding for the 64-step frame assembler.
package frame_assembler64_pkg;
    localparam int FRAME_W = 64;
    localparam int CNT_W   = $clog2(FRAME_W);

    typedef enum logic {IDLE, COLLECT} asm_state_t;
endpackage

// File: rtl/frame_assembler64_frame_out_reg.sv
// Output holding register: presents one frame over valid/ready and flags dropped frames.
module frame_out_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             overrun
);
    logic accept;

    assign accept = valid && ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load && (!valid || accept)) begin
                data  <= load_data;
                valid <= 1'b1;
            end else if (load) begin
                // Held frame still unconsumed: keep it and drop the new one.
                overrun <= 1'b1;
            end else if (accept) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/frame_assembler64.sv
// Assembles one serial bit per counter index into a 64-bit frame per clean 0..63 sweep.
module frame_assembler64
    import frame_assembler64_pkg::*;
#(
    parameter int WIDTH = FRAME_W,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count,
    input  logic             bit_in,
    output logic [WIDTH-1:0] frame_data,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             seq_error,
    output logic             overrun
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    asm_state_t       state;
    logic [WIDTH-1:0] asm_buf;
    logic [WIDTH-1:0] frame_next;
    logic [WIDTH-1:0] frame_start;
    logic [CNT_W-1:0] prev_count;
    logic [CNT_W-1:0] expected;
    logic             is_repeat;
    logic             is_advance;
    logic             complete;

    always_comb begin
        frame_next        = asm_buf;
        frame_next[count] = bit_in;
    end

    assign frame_start = {{(WIDTH-1){1'b0}}, bit_in};
    assign is_repeat   = (count == prev_count);
    assign is_advance  = (count == expected);
    assign complete    = (state == COLLECT) && !is_repeat && is_advance && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            asm_buf    <= '0;
            prev_count <= '0;
            expected   <= '0;
            seq_error  <= 1'b0;
        end else begin
            seq_error  <= 1'b0;
            prev_count <= count;
            case (state)
                IDLE: begin
                    if (count == '0) begin
                        asm_buf  <= frame_start;
                        expected <= ONE;
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    // A repeat covers the doubled 0 after a counter wrap; last sample wins.
                    if (is_repeat) begin
                        asm_buf <= frame_next;
                    end else if (is_advance) begin
                        asm_buf <= frame_next;
                        if (count == LAST) begin
                            state <= IDLE;
                        end else begin
                            expected <= expected + ONE;
                        end
                    end else begin
                        seq_error <= 1'b1;
                        if (count == '0) begin
                            asm_buf  <= frame_start;
                            expected <= ONE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    frame_out_reg #(
        .WIDTH(WIDTH)
    ) u_out (
        .clk      (clk),
        .rst      (rst),
        .load     (complete),
        .load_data(frame_next),
        .ready    (frame_ready),
        .data     (frame_data),
        .valid    (frame_valid),
        .overrun  (overrun)
    );
endmodule

// File: tb/tb_frame_assembler64.sv
// Scoreboard bench for frame_assembler64: driver feeds a sweep-level model, monitor checks DUT outputs.
module tb_frame_assembler64;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  count = 6'd0;
    logic        bit_in = 1'b0;
    logic [63:0] frame_data;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic        seq_error;
    logic        overrun;

    typedef struct packed {
        logic vld;
        logic err;
        logic ov;
    } rec_t;

    int checks = 0;
    int errors = 0;

    bit [63:0] fq[$];
    rec_t      rq[$];

    int        m_last;
    bit [63:0] m_acc;
    bit        m_vld;
    bit        m_ov;

    always #5 clk = ~clk;

    frame_assembler64 dut (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .bit_in     (bit_in),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .seq_error  (seq_error),
        .overrun    (overrun)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = -1;
        m_acc  = '0;
        m_vld  = 1'b0;
        m_ov   = 1'b0;
        fq.delete();
        rq.delete();
    endtask

    // Frame-level reference: m_last is the highest index collected so far, -1 when no frame is open.
    task automatic model_step(input int c, input bit b, input bit r);
        bit   err = 1'b0;
        bit   done = 1'b0;
        rec_t rec;
        if (m_last < 0) begin
            if (c == 0) begin
                m_acc = '0; m_acc[0] = b; m_last = 0;
            end
        end else if (c == m_last) begin
            m_acc[c] = b;
        end else if (c == m_last + 1) begin
            m_acc[c] = b;
            m_last = c;
            if (c == 63) begin
                done = 1'b1; m_last = -1;
            end
        end else begin
            err = 1'b1;
            if (c == 0) begin
                m_acc = '0; m_acc[0] = b; m_last = 0;
            end else begin
                m_last = -1;
            end
        end
        if (done) begin
            if (!m_vld || r) begin
                fq.push_back(m_acc);
                m_vld = 1'b1;
            end else begin
                m_ov = 1'b1;
            end
        end else if (m_vld && r) begin
            m_vld = 1'b0;
        end
        rec.vld = m_vld; rec.err = err; rec.ov = m_ov;
        rq.push_back(rec);
    endtask

    task automatic cycle(input int c, input bit b, input bit r);
        #1;
        count       = 6'(c);
        bit_in      = b;
        frame_ready = r;
        @(posedge clk);
        model_step(c, b, r);
    endtask

    task automatic sweep(input bit [63:0] pat, input bit r);
        cycle(0, pat[0], r);
        cycle(0, pat[0], r);
        for (int i = 1; i < 64; i++) cycle(i, pat[i], r);
    endtask

    task automatic idle(input int n, input bit r);
        repeat (n) cycle(40, 1'b0, r);
    endtask

    task automatic do_reset(input int n);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_frame_data", frame_data, 64'h0);
        chk("rst_frame_valid", {63'h0, frame_valid}, 64'h0);
        chk("rst_seq_error", {63'h0, seq_error}, 64'h0);
        chk("rst_overrun", {63'h0, overrun}, 64'h0);
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: per-cycle status from the record queue, frame contents from the frame queue.
    initial begin : monitor
        rec_t rec;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rq.size() > 0) begin
                    rec = rq.pop_front();
                    chk("frame_valid", {63'h0, frame_valid}, {63'h0, rec.vld});
                    chk("seq_error", {63'h0, seq_error}, {63'h0, rec.err});
                    chk("overrun", {63'h0, overrun}, {63'h0, rec.ov});
                end
                if (frame_valid) begin
                    if (fq.size() == 0) begin
                        chk("unexpected_frame", {63'h0, frame_valid}, 64'h0);
                    end else begin
                        chk("frame_data", frame_data, fq[0]);
                        if (frame_ready) void'(fq.pop_front());
                    end
                end
            end
        end
    end

    initial begin : driver
        bit [63:0] pat;
        model_reset();
        do_reset(2);

        // Reset in the middle of a sweep discards the partial frame.
        for (int i = 0; i <= 20; i++) cycle(i, 1'b1, 1'b1);
        do_reset(2);
        sweep(64'h0123_4567_89AB_CDEF, 1'b1);
        idle(3, 1'b1);

        // Normal sweep with bit_in = count[0].
        sweep(64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
        idle(3, 1'b1);

        // Back-to-back sweeps with ready held high.
        sweep(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        sweep(64'h0, 1'b1);
        idle(3, 1'b1);

        // Skip 2 -> 5, then a clean sweep.
        cycle(0, 1'b1, 1'b1);
        cycle(1, 1'b0, 1'b1);
        cycle(2, 1'b1, 1'b1);
        cycle(5, 1'b1, 1'b1);
        idle(3, 1'b1);
        sweep(64'h5555_0000_FFFF_1234, 1'b1);
        idle(3, 1'b1);

        // Jump back to 0 after index 30 restarts the frame.
        for (int i = 0; i <= 30; i++) cycle(i, 1'b1, 1'b1);
        sweep(64'hDEAD_BEEF_CAFE_F00D, 1'b1);
        idle(3, 1'b1);

        // Overrun: two frames with ready low, then drain.
        sweep(64'h1, 1'b0);
        sweep(64'h2, 1'b0);
        idle(4, 1'b0);
        idle(4, 1'b1);

        // Randomized sweeps with repeats, injected jumps and random ready.
        do_reset(1);
        for (int s = 0; s < 25; s++) begin
            pat = {$urandom, $urandom};
            cycle(0, pat[0], ($urandom % 4) != 0);
            cycle(0, pat[0], ($urandom % 4) != 0);
            for (int i = 1; i < 64; i++) begin
                if ($urandom % 40 == 0)
                    cycle(int'($urandom % 64), $urandom % 2 == 1, ($urandom % 4) != 0);
                cycle(i, pat[i], ($urandom % 4) != 0);
                if ($urandom % 8 == 0)
                    cycle(i, $urandom % 2 == 1, ($urandom % 4) != 0);
            end
            if ($urandom % 3 == 0) idle(int'($urandom % 4) + 1, ($urandom % 2) == 1);
        end
        idle(8, 1'b1);

        @(negedge clk);
        #1;
        chk("frames_drained", 64'(fq.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
